ad7606_conv_ctrl: RTL and testbench
===================================

Name: ad7606_conv_ctrl

Overview:
Sequences one AD7606 conversion-and-readback frame per trigger pulse from the periodic sample-enable generator. After reset it pulses the ADC reset pin, then waits for triggers. Each trigger drives CONVST, tracks BUSY, and reads CH_NUM channels over the 16-bit parallel bus using CS_N/RD_N. Each channel word is presented to the downstream capture logic with a valid strobe.

Parameters:
CH_NUM, 8, channels read per frame; legal range 1..8.
AD_RST_CYC, 10, clk cycles ad_reset_o is held high after rst deasserts.
CONVST_LOW_CYC, 5, clk cycles ad_convst_o is held low per conversion.
RD_LOW_CYC, 4, clk cycles ad_rd_n_o is held low per channel read.
RD_HIGH_CYC, 2, clk cycles ad_rd_n_o is held high between reads.
BUSY_TIMEOUT, 500, maximum clk cycles allowed in each BUSY wait phase.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
sample_en_i  in  1  one-cycle trigger pulse from the enable generator.
ad_busy_i  in  1  AD7606 BUSY; asynchronous to clk.
ad_frstdata_i  in  1  AD7606 FRSTDATA; used only when AD_FRSTDATA_CHK_EN is defined.
ad_data_i  in  16  AD7606 DB[15:0].
ad_reset_o  out  1  ADC reset pin.
ad_convst_o  out  1  CONVSTA/B, tied together.
ad_cs_n_o  out  1  ADC chip select, active low.
ad_rd_n_o  out  1  ADC read strobe, active low.
data_o  out  16  captured channel word.
data_ch_o  out  3  channel index of data_o.
data_vld_o  out  1  one-cycle strobe qualifying data_o and data_ch_o.
frame_done_o  out  1  one-cycle pulse after the last channel is read.
busy_o  out  1  high in every state except IDLE.
overrun_o  out  1  one-cycle pulse when a trigger is dropped.
timeout_o  out  1  one-cycle pulse when a BUSY wait times out.
frame_err_o  out  1  one-cycle pulse on a FRSTDATA error; constant 0 when the check is compiled out.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values, held during rst and in the cycle rst is sampled high:
  - ad_reset_o=0, ad_convst_o=1, ad_cs_n_o=1, ad_rd_n_o=1.
  - data_o=0, data_ch_o=0.
  - data_vld_o, frame_done_o, overrun_o, timeout_o, frame_err_o = 0.
  - busy_o=1.
  - State = ARST; all counters = 0.
- ad_busy_i passes through a 2-flop synchronizer; busy_s is the synchronized value. All BUSY decisions use busy_s.
- State machine; the cycle counter clears on every state entry:
  - ARST: ad_reset_o=1 for exactly AD_RST_CYC cycles, then go to IDLE.
  - IDLE: busy_o=0. If sample_en_i=1, go to CONV.
  - CONV: ad_convst_o=0 for CONVST_LOW_CYC cycles, beginning the cycle after the trigger is sampled. Then ad_convst_o=1 and go to WAIT_HI.
  - WAIT_HI: wait for busy_s=1, then go to WAIT_LO. If BUSY_TIMEOUT cycles elapse first, go to IDLE.
  - WAIT_LO: wait for busy_s=0. On busy_s=0, set ad_cs_n_o=0 and go to RD_L. If BUSY_TIMEOUT cycles elapse first, go to IDLE.
  - RD_L: ad_rd_n_o=0 for RD_LOW_CYC cycles. On the last low cycle, register ad_data_i into data_o and the channel counter into data_ch_o. data_vld_o pulses the next cycle. Go to RD_H.
  - RD_H: ad_rd_n_o=1 for RD_HIGH_CYC cycles. Then increment the channel counter and go back to RD_L, unless the channel just read was CH_NUM-1, in which case go to DONE.
  - DONE: ad_cs_n_o=1, frame_done_o=1 for one cycle, channel counter = 0, go to IDLE.
- Timeout: timeout_o pulses in the cycle the state returns to IDLE. ad_cs_n_o stays 1 and no data_vld_o is issued.
- Overrun: sample_en_i=1 in any state other than IDLE (ARST included) is dropped and overrun_o=1 in the following cycle. A trigger in the same cycle as the DONE→IDLE transition is also dropped.
- Channel counter is 3 bits and never exceeds CH_NUM-1. data_ch_o sequence per frame is 0..CH_NUM-1.
- rst asserted mid-frame: the FSM returns to ARST in the next cycle, bus outputs go idle immediately, any partial frame is discarded without frame_done_o, and the ADC reset pulse is reissued.
- Latency from trigger to first data_vld_o, with default parameters: 1 + CONVST_LOW_CYC + T_busy + 2 (synchronizer) + RD_LOW_CYC + 1.

Optional Feature:
AD_FRSTDATA_CHK_EN.
- Defined: on the channel-0 capture cycle, ad_frstdata_i must be 1. If it is 0:
  - data_vld_o is suppressed for that word.
  - frame_err_o pulses one cycle.
  - ad_cs_n_o and ad_rd_n_o return to 1.
  - The FSM goes to IDLE without frame_done_o.
- Not defined: ad_frstdata_i is ignored and frame_err_o is tied to 0.

Test Plan:
1. Power-up: rst high 3 cycles, then low → ad_reset_o high exactly 10 cycles, busy_o falls the cycle after it, all other outputs at their reset values.
2. Nominal frame: trigger, BUSY model high 40 cycles, ad_data_i = 16'h1000 + channel → 8 data_vld_o pulses with data_o 1000..1007 and data_ch_o 0..7, RD_N period 6 cycles, then one frame_done_o pulse.
3. Trigger every 250 cycles, with a second trigger injected mid-frame → that trigger produces a 1-cycle overrun_o, the frame completes with 8 words, and the next periodic trigger starts a new frame.
4. BUSY stuck low after CONV → timeout_o pulses exactly 500 cycles after WAIT_HI entry, no data_vld_o, back in IDLE. Repeat with BUSY stuck high in WAIT_LO → same response.
5. rst pulsed for 1 cycle during the RD_L of channel 3 → outputs idle the next cycle, no frame_done_o, ad_reset_o pulse reissued, the next trigger yields a full 0..7 frame.
6. With AD_FRSTDATA_CHK_EN defined and FRSTDATA=0 at channel 0 → frame_err_o pulses, zero data_vld_o pulses, CS_N returns high. With the macro undefined → a normal 8-word frame.

Source files
------------

// File: rtl/ad7606_conv_ctrl.sv
// AD7606 conversion/readback sequencer: one CONVST + CH_NUM parallel reads per trigger.
// Optional FRSTDATA alignment check compiled in with `define AD_FRSTDATA_CHK_EN.
module ad7606_conv_ctrl #(
    parameter int CH_NUM         = 8,
    parameter int AD_RST_CYC     = 10,
    parameter int CONVST_LOW_CYC = 5,
    parameter int RD_LOW_CYC     = 4,
    parameter int RD_HIGH_CYC    = 2,
    parameter int BUSY_TIMEOUT   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en_i,
    input  logic        ad_busy_i,
    input  logic        ad_frstdata_i,
    input  logic [15:0] ad_data_i,
    output logic        ad_reset_o,
    output logic        ad_convst_o,
    output logic        ad_cs_n_o,
    output logic        ad_rd_n_o,
    output logic [15:0] data_o,
    output logic [2:0]  data_ch_o,
    output logic        data_vld_o,
    output logic        frame_done_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o,
    output logic        frame_err_o
);

    localparam int M1      = (BUSY_TIMEOUT > AD_RST_CYC) ? BUSY_TIMEOUT : AD_RST_CYC;
    localparam int M2      = (CONVST_LOW_CYC > RD_LOW_CYC) ? CONVST_LOW_CYC : RD_LOW_CYC;
    localparam int M3      = (M2 > RD_HIGH_CYC) ? M2 : RD_HIGH_CYC;
    localparam int CNT_MAX = (M1 > M3) ? M1 : M3;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ARST, IDLE, CONV, WAIT_HI, WAIT_LO, RD_L, RD_H, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ch_cnt;
    logic             busy_meta;
    logic             busy_s;
    logic             frst_bad;

`ifdef AD_FRSTDATA_CHK_EN
    assign frst_bad = (ch_cnt == 3'd0) && !ad_frstdata_i;
`else
    logic frst_unused;
    assign frst_unused = ad_frstdata_i;
    assign frst_bad    = 1'b0;
`endif

    // BUSY comes straight off the ADC pin, unrelated to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= ad_busy_i;
            busy_s    <= busy_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARST;
            cnt          <= '0;
            ch_cnt       <= '0;
            ad_reset_o   <= 1'b0;
            ad_convst_o  <= 1'b1;
            ad_cs_n_o    <= 1'b1;
            ad_rd_n_o    <= 1'b1;
            data_o       <= '0;
            data_ch_o    <= '0;
            data_vld_o   <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b1;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            data_vld_o   <= 1'b0;
            frame_done_o <= 1'b0;
            timeout_o    <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= sample_en_i && (state != IDLE);

            case (state)
                ARST: begin
                    if (cnt == CNT_W'(AD_RST_CYC)) begin
                        ad_reset_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= IDLE;
                        cnt        <= '0;
                    end else begin
                        ad_reset_o <= 1'b1;
                        cnt        <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (sample_en_i) begin
                        ad_convst_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= CONV;
                        cnt         <= '0;
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(CONVST_LOW_CYC - 1)) begin
                        ad_convst_o <= 1'b1;
                        state       <= WAIT_HI;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (busy_s) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!busy_s) begin
                        ad_cs_n_o <= 1'b0;
                        ad_rd_n_o <= 1'b0;
                        state     <= RD_L;
                        cnt       <= '0;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_L: begin
                    if (cnt == CNT_W'(RD_LOW_CYC - 1)) begin
                        ad_rd_n_o <= 1'b1;
                        cnt       <= '0;
                        // Misaligned FRSTDATA means the ADC read pointer is off: drop the frame
                        if (frst_bad) begin
                            frame_err_o <= 1'b1;
                            ad_cs_n_o   <= 1'b1;
                            busy_o      <= 1'b0;
                            ch_cnt      <= '0;
                            state       <= IDLE;
                        end else begin
                            data_o     <= ad_data_i;
                            data_ch_o  <= ch_cnt;
                            data_vld_o <= 1'b1;
                            state      <= RD_H;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_H: begin
                    if (cnt == CNT_W'(RD_HIGH_CYC - 1)) begin
                        cnt <= '0;
                        if (ch_cnt == 3'(CH_NUM - 1)) begin
                            ad_cs_n_o    <= 1'b1;
                            frame_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            ch_cnt    <= ch_cnt + 1'b1;
                            ad_rd_n_o <= 1'b0;
                            state     <= RD_L;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ch_cnt <= '0;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= ARST;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_conv_ctrl.sv
// Directed bench for ad7606_conv_ctrl with a behavioural AD7606 BUSY/data model.
module tb_ad7606_conv_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sample_en_i = 1'b0;
    logic        ad_busy_i = 1'b0;
    logic        ad_frstdata_i;
    logic [15:0] ad_data_i;
    logic        ad_reset_o, ad_convst_o, ad_cs_n_o, ad_rd_n_o;
    logic [15:0] data_o;
    logic [2:0]  data_ch_o;
    logic        data_vld_o, frame_done_o, busy_o, overrun_o, timeout_o, frame_err_o;

    ad7606_conv_ctrl dut (
        .clk(clk), .rst(rst), .sample_en_i(sample_en_i), .ad_busy_i(ad_busy_i),
        .ad_frstdata_i(ad_frstdata_i), .ad_data_i(ad_data_i),
        .ad_reset_o(ad_reset_o), .ad_convst_o(ad_convst_o), .ad_cs_n_o(ad_cs_n_o),
        .ad_rd_n_o(ad_rd_n_o), .data_o(data_o), .data_ch_o(data_ch_o),
        .data_vld_o(data_vld_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o), .frame_err_o(frame_err_o)
    );

    // ADC model knobs: mode 0 = BUSY pulse of busy_len, 1 = stuck low, 2 = stuck high
    int          busy_mode = 0;
    int          busy_len  = 40;
    logic [15:0] base      = 16'h0;
    bit          frst_val  = 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   bcnt = 0, idx = 0;
    logic rd_prev = 1'b1, cv_prev = 1'b1, ar_prev = 1'b0;
    int   n_done = 0, n_ovr = 0, n_to = 0, n_ferr = 0, n_arst = 0;
    int   cv_rise = 0, to_cyc = 0;
    logic [15:0] got_data[$];
    logic [2:0]  got_ch[$];
    int          rd_fall[$];

    assign ad_data_i     = base + 16'(idx);
    assign ad_frstdata_i = (!ad_cs_n_o && idx == 0) ? frst_val : 1'b0;

    always @(negedge clk) begin
        if (busy_mode == 2) begin
            if (!cv_prev && ad_convst_o) ad_busy_i <= 1'b1;
        end else if (!cv_prev && ad_convst_o && busy_mode == 0) begin
            ad_busy_i <= 1'b1;
            bcnt      <= busy_len - 1;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end else begin
            ad_busy_i <= 1'b0;
        end
        if (ad_cs_n_o) idx <= 0;
        else if (!rd_prev && ad_rd_n_o) idx <= idx + 1;

        if (data_vld_o) begin
            got_data.push_back(data_o);
            got_ch.push_back(data_ch_o);
        end
        if (frame_done_o) n_done <= n_done + 1;
        if (overrun_o)    n_ovr  <= n_ovr + 1;
        if (timeout_o) begin n_to <= n_to + 1; to_cyc <= cyc; end
        if (frame_err_o)  n_ferr <= n_ferr + 1;
        if (!ar_prev && ad_reset_o) n_arst <= n_arst + 1;
        if (rd_prev && !ad_rd_n_o) rd_fall.push_back(cyc);
        if (!cv_prev && ad_convst_o) cv_rise <= cyc;
        rd_prev <= ad_rd_n_o;
        cv_prev <= ad_convst_o;
        ar_prev <= ad_reset_o;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic trig();
        sample_en_i = 1'b1;
        @(negedge clk);
        sample_en_i = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        int e0;
        e0 = n_done + n_to + n_ferr;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (n_done + n_to + n_ferr != e0) ok = 1'b1;
        end
    endtask

    typedef struct {
        int          busy_len;
        logic [15:0] base;
        bit          frst;
        int          words;
        int          done;
        int          ferr;
    } vec_t;

    vec_t vt[4];

    task automatic run_vec(input vec_t v, input string nm);
        int q0, d0, f0, t0, o0, r0;
        bit ok;
        q0 = got_data.size(); r0 = rd_fall.size();
        d0 = n_done; f0 = n_ferr; t0 = n_to; o0 = n_ovr;
        busy_mode = 0; busy_len = v.busy_len; base = v.base; frst_val = v.frst;
        trig();
        wait_end(2000, ok);
        tick(4);
        chk($sformatf("%s_end", nm), 32'(ok), 1);
        chk($sformatf("%s_words", nm), got_data.size() - q0, v.words);
        for (int i = 0; i < v.words; i++) begin
            if (q0 + i < got_data.size()) begin
                chk($sformatf("%s_data%0d", nm, i), 32'(got_data[q0 + i]), 32'(v.base) + i);
                chk($sformatf("%s_ch%0d", nm, i), 32'(got_ch[q0 + i]), i);
            end
        end
        chk($sformatf("%s_done", nm), n_done - d0, v.done);
        chk($sformatf("%s_ferr", nm), n_ferr - f0, v.ferr);
        chk($sformatf("%s_to", nm), n_to - t0, 0);
        chk($sformatf("%s_ovr", nm), n_ovr - o0, 0);
        chk($sformatf("%s_idle", nm), 32'({ad_cs_n_o, ad_rd_n_o, busy_o}), 32'b110);
        if (v.words == 8) begin
            chk($sformatf("%s_rdcnt", nm), rd_fall.size() - r0, 8);
            if (rd_fall.size() - r0 >= 2)
                chk($sformatf("%s_rdper", nm), rd_fall[r0 + 1] - rd_fall[r0], 6);
        end
    endtask

    initial begin
        int  hi, q0, d0, o0, t0, a0;
        bit  seen, bsy_hi, ok;

        vt[0] = '{40, 16'h1000, 1'b1, 8, 1, 0};
        vt[1] = '{10, 16'hA5A0, 1'b1, 8, 1, 0};
        vt[2] = '{1,  16'hFFF0, 1'b1, 8, 1, 0};
`ifdef AD_FRSTDATA_CHK_EN
        vt[3] = '{40, 16'h2000, 1'b0, 0, 0, 1};
`else
        vt[3] = '{40, 16'h2000, 1'b0, 8, 1, 0};
`endif

        // power-up
        rst = 1'b1;
        tick(3);
        chk("rst_ctrl", 32'({ad_reset_o, ad_convst_o, ad_cs_n_o, ad_rd_n_o, busy_o}), 32'b01111);
        chk("rst_pulses", 32'({data_vld_o, frame_done_o, overrun_o, timeout_o, frame_err_o}), 0);
        chk("rst_data", 32'({data_o, data_ch_o}), 0);
        rst = 1'b0;
        hi = 0; seen = 1'b0; bsy_hi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ad_reset_o) begin
                hi++;
                bsy_hi = busy_o;
            end else if (hi > 0 && !seen) begin
                seen = 1'b1;
                chk("busy_after_arst", 32'(busy_o), 0);
                chk("bus_after_arst", 32'({ad_convst_o, ad_cs_n_o, ad_rd_n_o}), 32'b111);
            end
        end
        chk("arst_len", hi, 10);
        chk("arst_end_seen", 32'(seen), 1);
        chk("busy_during_arst", 32'(bsy_hi), 1);

        for (int k = 0; k < 4; k++) begin
            run_vec(vt[k], $sformatf("vec%0d", k));
            tick(5);
        end

        // periodic triggers every 250 cycles with one injected mid-frame
        q0 = got_data.size(); d0 = n_done; o0 = n_ovr;
        busy_len = 40; base = 16'h3000; frst_val = 1'b1;
        trig();
        tick(58);
        trig();
        tick(190);
        trig();
        for (int i = 0; i < 600 && (n_done - d0) < 2; i++) @(negedge clk);
        tick(4);
        chk("per_words", got_data.size() - q0, 16);
        chk("per_done", n_done - d0, 2);
        chk("per_ovr", n_ovr - o0, 1);
        for (int i = 0; i < 16; i++)
            if (q0 + i < got_data.size())
                chk($sformatf("per_data%0d", i), 32'({got_ch[q0 + i], got_data[q0 + i]}),
                    32'({3'(i % 8), 16'h3000 + 16'(i % 8)}));

        // trigger landing in the DONE cycle is dropped
        q0 = got_data.size(); o0 = n_ovr; seen = 1'b0;
        base = 16'h5000;
        trig();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_done_o) begin seen = 1'b1; break; end
        end
        sample_en_i = 1'b1;
        @(negedge clk);
        sample_en_i = 1'b0;
        tick(3);
        chk("done_trig_seen", 32'(seen), 1);
        chk("done_trig_ovr", n_ovr - o0, 1);
        chk("done_trig_idle", 32'({busy_o, ad_cs_n_o, ad_convst_o}), 32'b011);
        chk("done_trig_words", got_data.size() - q0, 8);

        // BUSY never rises
        q0 = got_data.size(); t0 = n_to;
        busy_mode = 1;
        trig();
        wait_end(1000, ok);
        tick(3);
        chk("to_lo_end", 32'(ok), 1);
        chk("to_lo_cnt", n_to - t0, 1);
        chk("to_lo_delay", to_cyc - cv_rise, 500);
        chk("to_lo_words", got_data.size() - q0, 0);
        chk("to_lo_idle", 32'({busy_o, ad_cs_n_o}), 32'b01);

        // BUSY never falls
        t0 = n_to;
        busy_mode = 2;
        trig();
        wait_end(1000, ok);
        tick(3);
        chk("to_hi_end", 32'(ok), 1);
        chk("to_hi_cnt", n_to - t0, 1);
        chk("to_hi_words", got_data.size() - q0, 0);
        chk("to_hi_idle", 32'({busy_o, ad_cs_n_o, ad_rd_n_o}), 32'b011);
        busy_mode = 0;
        tick(5);

        // rst during channel 3 read, then a trigger inside the reissued ADC reset
        q0 = got_data.size(); d0 = n_done; o0 = n_ovr; a0 = n_arst;
        busy_len = 40; base = 16'h4000;
        trig();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!ad_cs_n_o && !ad_rd_n_o && idx == 3) begin seen = 1'b1; break; end
        end
        chk("mid_rst_reached", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_bus", 32'({ad_cs_n_o, ad_rd_n_o, ad_convst_o, ad_reset_o, busy_o, data_vld_o}),
            32'b111010);
        tick(3);
        chk("mid_rst_arst", 32'(ad_reset_o), 1);
        trig();
        tick(20);
        chk("mid_rst_ovr", n_ovr - o0, 1);
        chk("mid_rst_done", n_done - d0, 0);
        chk("mid_rst_words", got_data.size() - q0, 3);
        chk("mid_rst_npulse", n_arst - a0, 1);
        chk("mid_rst_idle", 32'({busy_o, ad_cs_n_o, ad_reset_o}), 32'b010);
        run_vec(vt[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
